// File: rtl/pipelined_lookahead_subtractor.sv
// pipelined_lookahead_subtractor
// diff = a - b - borrow_in, resolved W = N/STAGES bits per register slice.
// Each slice does a full borrow-lookahead over its W bits and hands a
// registered borrow to the next slice. Operand bits still to be consumed are
// skewed forward, and finished diff bits accumulate so they leave aligned.
// The whole pipeline advances together on adv = !out_valid | out_ready.
// Optional feature macro: SUB_FLAGS_EN (ovf and zero flags). When it is
// undefined, ovf and zero are tied low and their registers are not built.
module pipelined_lookahead_subtractor #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         borrow_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         borrow_out,
  output logic         ovf,
  output logic         zero
);

  localparam int W = N / STAGES;

  // Slice subtract in sum-of-products lookahead form: every borrow is built
  // from G/P terms and the slice borrow-in directly, not by rippling.
  function automatic logic [W:0] f_sub(input logic [W-1:0] x,
                                       input logic [W-1:0] y,
                                       input logic         bin);
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   br;
    logic         t;
    g     = ~x & y;
    p     = ~(x ^ y);
    br    = '0;
    br[0] = bin;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int m = j + 1; m <= i; m++) t = t & p[m];
        br[i+1] = br[i+1] | t;
      end
      t = bin;
      for (int m = 0; m <= i; m++) t = t & p[m];
      br[i+1] = br[i+1] | t;
    end
    return {br[W], x ^ y ^ br[W-1:0]};
  endfunction

  logic w_adv;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv && !rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO  = k * W;
    localparam int HI  = LO + W;
    localparam int REM = N - HI;

    logic [N-LO-1:0] w_src_a;
    logic [N-LO-1:0] w_src_b;
    logic            w_bin;
    logic            w_vin;
    logic [W:0]      w_res;
    logic [HI-1:0]   w_diff_nxt;
    logic            r_vld;
    logic            r_brw;
    logic [HI-1:0]   r_diff;

    if (k == 0) begin : g_head
      assign w_src_a    = a;
      assign w_src_b    = b;
      assign w_bin      = borrow_in;
      assign w_vin      = in_valid && in_ready;
      assign w_diff_nxt = w_res[W-1:0];
    end else begin : g_tail
      assign w_src_a    = g_stg[k-1].g_rem.r_a_rem;
      assign w_src_b    = g_stg[k-1].g_rem.r_b_rem;
      assign w_bin      = g_stg[k-1].r_brw;
      assign w_vin      = g_stg[k-1].r_vld;
      assign w_diff_nxt = {w_res[W-1:0], g_stg[k-1].r_diff};
    end

    assign w_res = f_sub(w_src_a[W-1:0], w_src_b[W-1:0], w_bin);

    // slice result register: valid, borrow to the next slice, diff so far
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld  <= 1'b0;
        r_brw  <= 1'b0;
        r_diff <= '0;
      end else if (w_adv) begin
        r_vld  <= w_vin;
        r_brw  <= w_res[W];
        r_diff <= w_diff_nxt;
      end
    end

    if (REM > 0) begin : g_rem
      logic [REM-1:0] r_a_rem;
      logic [REM-1:0] r_b_rem;
      // skew the not-yet-consumed operand bits toward later slices
      always_ff @(posedge clk) begin
        if (rst) begin
          r_a_rem <= '0;
          r_b_rem <= '0;
        end else if (w_adv) begin
          r_a_rem <= w_src_a[N-LO-1:W];
          r_b_rem <= w_src_b[N-LO-1:W];
        end
      end
    end

`ifdef SUB_FLAGS_EN
    logic r_zero;
    logic w_zin;

    if (k == 0) begin : g_zhead
      assign w_zin = 1'b1;
    end else begin : g_ztail
      assign w_zin = g_stg[k-1].r_zero;
    end

    // running all-zero flag, one slice of zero-detect per stage
    always_ff @(posedge clk) begin
      if (rst)        r_zero <= 1'b0;
      else if (w_adv) r_zero <= w_zin && (w_res[W-1:0] == '0);
    end

    if (k == STAGES - 1) begin : g_ovf
      logic r_ovf;
      // the last slice holds both operand sign bits and the diff sign bit
      always_ff @(posedge clk) begin
        if (rst)        r_ovf <= 1'b0;
        else if (w_adv) r_ovf <= (w_src_a[W-1] ^ w_src_b[W-1]) &
                                 (w_res[W-1] ^ w_src_a[W-1]);
      end
    end
`endif
  end

  assign out_valid  = g_stg[STAGES-1].r_vld;
  assign diff       = g_stg[STAGES-1].r_diff;
  assign borrow_out = g_stg[STAGES-1].r_brw;

`ifdef SUB_FLAGS_EN
  assign ovf  = g_stg[STAGES-1].g_ovf.r_ovf;
  assign zero = g_stg[STAGES-1].r_zero;
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule
